instr_cache: RTL and testbench
==============================

# instr_cache

Direct-mapped, read-only instruction cache between the pipelined CPU's fetch port (PC, INSTRUCTION, INSTR_MEM_BUSYWAIT) and the block-wide instruction memory. Hits return the instruction in the same cycle with busywait low. Misses stall fetch through INSTR_MEM_BUSYWAIT while a three-state FSM fetches the whole block from memory and refills the line.

## Interface

Parameters:
- NUM_SETS, 8: number of lines. Power of two.
- WORDS_PER_BLOCK, 4: 32-bit words per line. Power of two.
- Derived: OFFSET_BITS = log2(WORDS_PER_BLOCK), INDEX_BITS = log2(NUM_SETS), TAG_BITS = 30 − OFFSET_BITS − INDEX_BITS.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset, asynchronous, active-low: RESET = 0 resets immediately.
- PC  in  32  fetch address from the CPU. PC[1:0] is ignored.
- INSTRUCTION  out  32  instruction word to the CPU.
- INSTR_MEM_BUSYWAIT  out  1  stall request to the CPU.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDR  out  30−OFFSET_BITS  block address, equal to PC[31:2+OFFSET_BITS] of the missing block.
- MEM_READ_DATA  in  32×WORDS_PER_BLOCK  returned block. Word 0 is in bits [31:0].
- MEM_BUSYWAIT  in  1  high while memory is servicing a read.

## Operation

- Address split: offset = PC[2+OFFSET_BITS−1:2]; index is the next INDEX_BITS bits; tag is the remaining upper bits.
- Per-line storage: valid bit, tag, WORDS_PER_BLOCK data words.
- hit = valid[index] && tag[index] == PC tag. This is combinational from PC and the arrays.
- FSM states: IDLE, MEM_READ, REFILL.
  - IDLE: on a hit, INSTRUCTION = data[index][offset] and INSTR_MEM_BUSYWAIT = 0. On a miss, INSTR_MEM_BUSYWAIT = 1 combinationally in the same cycle, the PC block address and index are latched, and the next state is MEM_READ.
  - MEM_READ: MEM_READ = 1, MEM_ADDR = latched block address, INSTR_MEM_BUSYWAIT = 1. Stay while MEM_BUSYWAIT = 1. At the first edge that samples MEM_BUSYWAIT = 0, register MEM_READ_DATA into the line buffer and go to REFILL.
  - REFILL: write the line buffer, latched tag, and valid = 1 into the latched index. INSTR_MEM_BUSYWAIT = 1 and MEM_READ = 0. Next state is IDLE unconditionally.
- Whenever INSTR_MEM_BUSYWAIT = 1, INSTRUCTION = 32'h00000013 (NOP). The pipeline therefore never sees stale data.
- MEM_ADDR is don't-care when MEM_READ = 0. It is driven from the latch, so it is stable.
- The cache is read-only. There is no write port and no flush other than reset.

## Timing

- Reset values (asynchronous, RESET = 0):
  - state = IDLE.
  - All valid bits = 0.
  - MEM_READ = 0.
  - INSTR_MEM_BUSYWAIT reflects a miss on the current PC. Because all lines are invalid, it is 1 once reset is released.
  - INSTRUCTION = NOP.
- Hit latency: 0 cycles. The result is combinational from PC.
- Miss penalty: 1 cycle (IDLE→MEM_READ) + N cycles in MEM_READ (N ≥ 1, the memory busywait length) + 1 cycle REFILL. The re-evaluated hit appears in the cycle after REFILL.
- The CPU holds PC while INSTR_MEM_BUSYWAIT = 1. If PC changes anyway, the in-flight fill completes for the latched block, and the new PC is evaluated in IDLE afterwards.
- Reset asserted mid-fill: the fill is abandoned, MEM_READ drops asynchronously, and no line is written.
- A refill to an index holding a valid line with a different tag overwrites that line (conflict eviction).
- MEM_READ_DATA is sampled only on the MEM_READ→REFILL edge and ignored at all other times.

## Structure

- Shared package (icache_pkg):
  - State encoding constants: IDLE = 2'd0, MEM_READ = 2'd1, REFILL = 2'd2.
  - NOP constant 32'h00000013, also used by the CPU hazard unit.
  - Default NUM_SETS / WORDS_PER_BLOCK.
- One sub-module, icache_array: valid/tag/data storage with an asynchronous read port, one synchronous write port, and an asynchronous clear of the valid bits. The FSM and hit logic live in instr_cache.

## Test plan

All scenarios use a memory model that returns a block after N = 4 busywait cycles. Each scenario lists stimulus → required response.

- Cold miss:
  - Stimulus: release reset, PC = 0x00000000; memory block 0 = {0x00400193, 0x00300213, 0x00000013, 0x00100093}, word 0 first.
  - Response: busywait high for 6 cycles, MEM_READ high with MEM_ADDR = 0 for 4 cycles. After that, INSTRUCTION = 0x00400193 with busywait low.
- Same-block hits:
  - Stimulus: PC = 0x4, then 0x8, then 0xC.
  - Response: INSTRUCTION = 0x00300213, then 0x00000013, then 0x00100093. Busywait stays low and MEM_READ never asserts.
- Conflict eviction:
  - Stimulus: PC = 0x80 (index 0, tag 1), then PC = 0x0.
  - Response: each access misses and performs a full refill. Afterwards MEM_ADDR history = 0x8, 0x0.
- Long memory stall:
  - Stimulus: memory busywait held for 20 cycles on PC = 0x40.
  - Response: MEM_READ stays high for 20 cycles, INSTRUCTION = NOP throughout, and the correct word appears after REFILL.
- Reset during MEM_READ:
  - Stimulus: assert RESET = 0 in the 2nd MEM_READ cycle for PC = 0x10.
  - Response: MEM_READ = 0 immediately. After release, PC = 0x10 misses again, because no partial line was written.
- Offset sweep:
  - Stimulus: refill block 0x20, then PC = 0x20, 0x24, 0x28, 0x2C.
  - Response: the four distinct words come back in order, each with a 0-cycle hit.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: fetch FSM encoding,
// the NOP word handed to the pipeline during stalls, and default geometry.
package icache_pkg;

   localparam int DEFAULT_NUM_SETS        = 8;
   localparam int DEFAULT_WORDS_PER_BLOCK = 4;

   // addi x0, x0, 0 -- also used by the CPU hazard unit as its bubble
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_READ = 2'd1,
      ST_REFILL   = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Asynchronous read port, one synchronous write port, and the valid bits
// are cleared asynchronously by reset so every line starts invalid.
module icache_array
   import icache_pkg::*;
#(
   parameter  int NUM_SETS        = DEFAULT_NUM_SETS,
   parameter  int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
   localparam int OFFSET_BITS     = $clog2(WORDS_PER_BLOCK),
   localparam int INDEX_BITS      = $clog2(NUM_SETS),
   localparam int TAG_BITS        = 30 - OFFSET_BITS - INDEX_BITS
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [INDEX_BITS-1:0]                 rd_index,
   output logic                                  rd_valid,
   output logic [TAG_BITS-1:0]                   rd_tag,
   output logic [WORDS_PER_BLOCK-1:0][31:0]      rd_block,
   input  logic                                  wr_en,
   input  logic [INDEX_BITS-1:0]                 wr_index,
   input  logic [TAG_BITS-1:0]                   wr_tag,
   input  logic [WORDS_PER_BLOCK-1:0][31:0]      wr_block
);

   logic [NUM_SETS-1:0]                      valid_bits;
   logic [TAG_BITS-1:0]                      tag_mem  [NUM_SETS];
   logic [WORDS_PER_BLOCK-1:0][31:0]         data_mem [NUM_SETS];

   // Valid bits: cleared by reset, set when a refill lands in a line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_bits <= '0;
      end else if (wr_en) begin
         valid_bits[wr_index] <= 1'b1;
      end
   end

   // Tag and data payload need no reset; they are only trusted once valid
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_block;
      end
   end

   assign rd_valid = valid_bits[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_block = data_mem[rd_index];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache. Hits answer combinationally
// from PC; misses hold the CPU on INSTR_MEM_BUSYWAIT while a three-state
// FSM reads the whole block from instruction memory and refills the line.
module instr_cache
   import icache_pkg::*;
#(
   parameter  int NUM_SETS        = DEFAULT_NUM_SETS,
   parameter  int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
   localparam int OFFSET_BITS     = $clog2(WORDS_PER_BLOCK),
   localparam int INDEX_BITS      = $clog2(NUM_SETS),
   localparam int TAG_BITS        = 30 - OFFSET_BITS - INDEX_BITS,
   localparam int BLK_BITS        = 30 - OFFSET_BITS
) (
   input  logic                             CLK,
   input  logic                             RESET,
   input  logic [31:0]                      PC,
   output logic [31:0]                      INSTRUCTION,
   output logic                             INSTR_MEM_BUSYWAIT,
   output logic                             MEM_READ,
   output logic [BLK_BITS-1:0]              MEM_ADDR,
   input  logic [32*WORDS_PER_BLOCK-1:0]    MEM_READ_DATA,
   input  logic                             MEM_BUSYWAIT
);

   fetch_state_t                        state, next_state;

   logic [OFFSET_BITS-1:0]              pc_offset;
   logic [INDEX_BITS-1:0]               pc_index;
   logic [TAG_BITS-1:0]                 pc_tag;
   logic [BLK_BITS-1:0]                 pc_block;
   logic                                unused_pc_lsbs;

   logic                                line_valid;
   logic [TAG_BITS-1:0]                 line_tag;
   logic [WORDS_PER_BLOCK-1:0][31:0]    line_block;
   logic                                hit;

   logic [BLK_BITS-1:0]                 blk_addr_q;
   logic [WORDS_PER_BLOCK-1:0][31:0]    line_buf;
   logic                                latch_miss;
   logic                                capture_line;
   logic                                refill_we;

   assign pc_offset      = PC[2 +: OFFSET_BITS];
   assign pc_index       = PC[2+OFFSET_BITS +: INDEX_BITS];
   assign pc_tag         = PC[31 -: TAG_BITS];
   assign pc_block       = PC[31 -: BLK_BITS];
   assign unused_pc_lsbs = ^PC[1:0];

   icache_array #(
      .NUM_SETS        (NUM_SETS),
      .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
   ) u_array (
      .clk      (CLK),
      .rst_n    (RESET),
      .rd_index (pc_index),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_block (line_block),
      .wr_en    (refill_we),
      .wr_index (blk_addr_q[INDEX_BITS-1:0]),
      .wr_tag   (blk_addr_q[BLK_BITS-1:INDEX_BITS]),
      .wr_block (line_buf)
   );

   assign hit      = line_valid && (line_tag == pc_tag);
   assign MEM_ADDR = blk_addr_q;

   // FSM state register; reset abandons any fill in flight
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Miss block address latch and line buffer for the returned block
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         blk_addr_q <= '0;
         line_buf   <= '0;
      end else begin
         if (latch_miss) begin
            blk_addr_q <= pc_block;
         end
         if (capture_line) begin
            line_buf <= MEM_READ_DATA;
         end
      end
   end

   // Next-state and fetch-port outputs; stall shows NOP so no stale word leaks
   always_comb begin
      next_state         = state;
      INSTRUCTION        = NOP_INSTR;
      INSTR_MEM_BUSYWAIT = 1'b1;
      MEM_READ           = 1'b0;
      latch_miss         = 1'b0;
      capture_line       = 1'b0;
      refill_we          = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (hit) begin
               INSTRUCTION        = line_block[pc_offset];
               INSTR_MEM_BUSYWAIT = 1'b0;
            end else begin
               latch_miss = 1'b1;
               next_state = ST_MEM_READ;
            end
         end
         ST_MEM_READ: begin
            MEM_READ = 1'b1;
            if (!MEM_BUSYWAIT) begin
               capture_line = 1'b1;
               next_state   = ST_REFILL;
            end
         end
         ST_REFILL: begin
            refill_we  = 1'b1;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_cache.sv
// Directed self-checking bench for instr_cache: cold miss, same-block hits,
// conflict eviction, long memory stall, reset mid-fill and an offset sweep.
module tb_instr_cache;
   import icache_pkg::*;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic [31:0]   PC = 32'h0;
   logic [31:0]   INSTRUCTION;
   logic          INSTR_MEM_BUSYWAIT;
   logic          MEM_READ;
   logic [27:0]   MEM_ADDR;
   logic [127:0]  MEM_READ_DATA;
   logic          MEM_BUSYWAIT;

   int            checks = 0;
   int            errors = 0;
   int            mem_latency = 4;
   int            mem_cnt = 0;
   logic [31:0]   mem_words [0:255];
   logic [27:0]   addr_hist [$];

   instr_cache dut (
      .CLK                (CLK),
      .RESET              (RESET),
      .PC                 (PC),
      .INSTRUCTION        (INSTRUCTION),
      .INSTR_MEM_BUSYWAIT (INSTR_MEM_BUSYWAIT),
      .MEM_READ           (MEM_READ),
      .MEM_ADDR           (MEM_ADDR),
      .MEM_READ_DATA      (MEM_READ_DATA),
      .MEM_BUSYWAIT       (MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   // Memory model: counts cycles of an active read, releases busywait after mem_latency
   always @(posedge CLK) begin
      if (MEM_READ) mem_cnt <= mem_cnt + 1;
      else          mem_cnt <= 0;
   end

   assign MEM_BUSYWAIT = MEM_READ && (mem_cnt != mem_latency - 1);

   // Block returned for the current MEM_ADDR, word 0 in the low bits
   always_comb begin
      MEM_READ_DATA = '0;
      for (int i = 0; i < 4; i++) begin
         MEM_READ_DATA[32*i +: 32] = mem_words[{MEM_ADDR[5:0], 2'(i)}];
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one miss from the IDLE cycle until busywait drops, then checks the result
   task automatic applyStimulus(input string tag, input logic [27:0] exp_addr,
                                input int exp_busy, input int exp_rd,
                                input logic [31:0] exp_instr);
      int busy_n   = 0;
      int rd_n     = 0;
      int nop_bad  = 0;
      int addr_bad = 0;
      bit first    = 1'b1;
      for (int cyc = 0; cyc < 200 && INSTR_MEM_BUSYWAIT; cyc++) begin
         busy_n++;
         if (INSTRUCTION !== NOP_INSTR) nop_bad++;
         if (MEM_READ) begin
            rd_n++;
            if (MEM_ADDR !== exp_addr) addr_bad++;
            if (first) begin
               addr_hist.push_back(MEM_ADDR);
               first = 1'b0;
            end
         end
         step();
      end
      check({tag, "_busy_cycles"}, busy_n, exp_busy);
      check({tag, "_read_cycles"}, rd_n, exp_rd);
      check({tag, "_addr_errors"}, addr_bad, 0);
      check({tag, "_nop_errors"}, nop_bad, 0);
      check({tag, "_instr"}, INSTRUCTION, exp_instr);
      check({tag, "_busy_low"}, {31'b0, INSTR_MEM_BUSYWAIT}, 32'd0);
   endtask

   // A zero-cycle hit: word returned combinationally with no stall and no read
   task automatic checkOutput(input string tag, input logic [31:0] pc_val,
                              input logic [31:0] exp_instr);
      PC = pc_val;
      #1;
      check({tag, "_instr"}, INSTRUCTION, exp_instr);
      check({tag, "_busy"}, {31'b0, INSTR_MEM_BUSYWAIT}, 32'd0);
      check({tag, "_memread"}, {31'b0, MEM_READ}, 32'd0);
      step();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_words[i] = 32'hA000_0000 | 32'(i);
      mem_words[0] = 32'h00400193;
      mem_words[1] = 32'h00300213;
      mem_words[2] = 32'h00000013;
      mem_words[3] = 32'h00100093;

      #3;
      check("reset_busy", {31'b0, INSTR_MEM_BUSYWAIT}, 32'd1);
      check("reset_memread", {31'b0, MEM_READ}, 32'd0);
      check("reset_instr", INSTRUCTION, NOP_INSTR);
      step();
      step();
      RESET = 1'b1;
      #1;
      applyStimulus("cold", 28'h0, 6, 4, 32'h00400193);

      checkOutput("hit_4", 32'h4, 32'h00300213);
      checkOutput("hit_8", 32'h8, 32'h00000013);
      checkOutput("hit_c", 32'hC, 32'h00100093);

      addr_hist.delete();
      PC = 32'h80;
      #1;
      applyStimulus("evict_a", 28'h8, 6, 4, 32'hA000_0020);
      PC = 32'h0;
      #1;
      applyStimulus("evict_b", 28'h0, 6, 4, 32'h00400193);
      check("hist_size", addr_hist.size(), 2);
      check("hist_0", {4'b0, addr_hist[0]}, 32'h8);
      check("hist_1", {4'b0, addr_hist[1]}, 32'h0);

      mem_latency = 20;
      PC = 32'h40;
      #1;
      applyStimulus("long", 28'h4, 22, 20, 32'hA000_0010);
      mem_latency = 4;

      PC = 32'h10;
      #1;
      check("rst_fill_miss", {31'b0, INSTR_MEM_BUSYWAIT}, 32'd1);
      step();
      check("rst_fill_read1", {31'b0, MEM_READ}, 32'd1);
      step();
      RESET = 1'b0;
      #1;
      check("rst_fill_memread", {31'b0, MEM_READ}, 32'd0);
      check("rst_fill_busy", {31'b0, INSTR_MEM_BUSYWAIT}, 32'd1);
      check("rst_fill_instr", INSTRUCTION, NOP_INSTR);
      step();
      RESET = 1'b1;
      #1;
      applyStimulus("after_reset", 28'h1, 6, 4, 32'hA000_0004);

      PC = 32'h20;
      #1;
      applyStimulus("sweep_fill", 28'h2, 6, 4, 32'hA000_0008);
      checkOutput("sweep_24", 32'h24, 32'hA000_0009);
      checkOutput("sweep_28", 32'h28, 32'hA000_000A);
      checkOutput("sweep_2c", 32'h2C, 32'hA000_000B);
      checkOutput("sweep_20", 32'h20, 32'hA000_0008);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
